// File: rtl/outer_prod_gen.sv
// -----------------------------------------------------------------------------
// outer_prod_gen
//   Captures a snapshot of scalar x and streams x*K[0..len-1]. K is read from
//   an external coefficient memory. Each product is scaled by 2**-FRAC, with
//   optional round-half-up, and saturated to OW bits. One element is produced
//   per cycle. The first element appears 5 cycles after the start cycle.
//
// Ports
//   clk         clock
//   rst_n       synchronous reset, active low
//   start       begin a run; x and len sampled this cycle (len==0 is ignored)
//   x           signed scalar, sampled only on an accepted start
//   len         vector length, 0..2**AW
//   k_addr      coefficient read address (registered read, 1-cycle latency)
//   k_data      signed coefficient returned for k_addr
//   result      signed scaled/saturated product, held while result_vld=0
//   result_vld  result valid
//   result_idx  element index of result
//   sat         result was clamped (qualified by result_vld)
//   done        one-cycle pulse with the last element of a run
//   busy        run in progress, from the cycle after start through done
//
// States
//   IDLE | no addresses issued; pc holds its last value
//   RUN  | one coefficient address issued per cycle, k_addr = pc
// -----------------------------------------------------------------------------
module outer_prod_gen #(
  parameter int XW   = 18,
  parameter int KW   = 18,
  parameter int OW   = 18,
  parameter int AW   = 10,
  parameter int FRAC = 17,
  parameter int RND  = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic signed [XW-1:0] x,
  input  logic [AW:0]          len,
  output logic [AW-1:0]        k_addr,
  input  logic signed [KW-1:0] k_data,
  output logic signed [OW-1:0] result,
  output logic                 result_vld,
  output logic [AW-1:0]        result_idx,
  output logic                 sat,
  output logic                 done,
  output logic                 busy
);

  localparam int PW  = XW + KW;
  // One guard bit so the rounding constant can never overflow the product.
  localparam int EW  = PW + 1;
  localparam int RSH = (FRAC > 0) ? FRAC - 1 : 0;

  localparam logic signed [EW-1:0] RND_ADD =
    (RND != 0 && FRAC > 0) ? (EW'(1) << RSH) : EW'(0);
  localparam logic signed [EW-1:0] SMAX = (EW'(1) << (OW - 1)) - EW'(1);
  localparam logic signed [EW-1:0] SMIN = ~SMAX;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t                state;
  logic [AW-1:0]         pc;
  logic signed [XW-1:0]  x_hold;
  logic [AW:0]           len_hold;

  // Pipeline tags: stage 1 = memory output, 2 = k_r, 3 = product
  logic                  v1, v2, v3;
  logic [AW-1:0]         i1, i2, i3;
  logic signed [KW-1:0]  k_r;
  logic signed [PW-1:0]  prod;

  logic                  go;
  logic                  last_issue;
  logic                  last_res;
  logic signed [EW-1:0]  p_ext;
  logic signed [EW-1:0]  p_rnd;
  logic signed [EW-1:0]  s_shift;
  logic                  sat_hi;
  logic                  sat_lo;
  logic signed [OW-1:0]  s_res;

  assign go         = start && (len != '0);
  assign k_addr     = pc;
  assign last_issue = ({1'b0, pc} == (len_hold - 1'b1));
  assign last_res   = ({1'b0, i3} == (len_hold - 1'b1));

  // Scale and clamp of the stage-3 product, registered into the output stage
  assign p_ext   = {prod[PW-1], prod};
  assign p_rnd   = p_ext + RND_ADD;
  assign s_shift = p_rnd >>> FRAC;
  assign sat_hi  = (s_shift > SMAX);
  assign sat_lo  = (s_shift < SMIN);

  always_comb begin
    s_res = s_shift[OW-1:0];
    if (sat_hi)
      s_res = SMAX[OW-1:0];
    else if (sat_lo)
      s_res = SMIN[OW-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= IDLE;
      pc         <= '0;
      x_hold     <= '0;
      len_hold   <= '0;
      v1         <= 1'b0;
      v2         <= 1'b0;
      v3         <= 1'b0;
      i1         <= '0;
      i2         <= '0;
      i3         <= '0;
      k_r        <= '0;
      prod       <= '0;
      result     <= '0;
      result_vld <= 1'b0;
      result_idx <= '0;
      sat        <= 1'b0;
      done       <= 1'b0;
      busy       <= 1'b0;
    end else begin
      // Address sequencer
      if (go) begin
        x_hold   <= x;
        len_hold <= len;
        pc       <= '0;
        state    <= RUN;
      end else if (state == RUN) begin
        // pc stops on the last address so a full 2**AW run never wraps
        if (last_issue)
          state <= IDLE;
        else
          pc <= pc + 1'b1;
      end

      // Datapath registers run freely; only the valid tags matter
      k_r  <= k_data;
      prod <= PW'(x_hold) * PW'(k_r);

      // An accepted start discards every in-flight element of an older run.
      // A done already on the outputs this cycle is still seen downstream.
      if (go) begin
        v1         <= 1'b0;
        v2         <= 1'b0;
        v3         <= 1'b0;
        result_vld <= 1'b0;
        done       <= 1'b0;
      end else begin
        v1         <= (state == RUN);
        i1         <= pc;
        v2         <= v1;
        i2         <= i1;
        v3         <= v2;
        i3         <= i2;
        result_vld <= v3;
        done       <= v3 && last_res;
        if (v3) begin
          result     <= s_res;
          result_idx <= i3;
          sat        <= sat_hi | sat_lo;
        end
      end

      if (go)
        busy <= 1'b1;
      else if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: tb/tb_outer_prod_gen.sv
module tb_outer_prod_gen;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Main DUT (truncating)
  logic               rst_n;
  logic               start;
  logic signed [17:0] x_req;
  logic signed [17:0] x_noise;
  logic signed [17:0] x_in;
  logic [10:0]        len;
  logic [9:0]         k_addr;
  logic signed [17:0] k_data;
  logic signed [17:0] result;
  logic               result_vld;
  logic [9:0]         result_idx;
  logic               sat;
  logic               done;
  logic               busy;
  logic signed [17:0] kmem [0:1023];

  // Rounding DUT
  logic               start2;
  logic signed [17:0] x2;
  logic [10:0]        len2;
  logic [9:0]         k_addr2;
  logic signed [17:0] k_data2;
  logic signed [17:0] result2;
  logic               result_vld2;
  logic [9:0]         result_idx2;
  logic               sat2;
  logic               done2;
  logic               busy2;
  logic signed [17:0] kmem2 [0:1023];

  // x wanders every cycle except while start is asserted
  always @(posedge clk) x_noise <= 18'($urandom);
  assign x_in = start ? x_req : x_noise;

  always @(posedge clk) k_data  <= kmem[k_addr];
  always @(posedge clk) k_data2 <= kmem2[k_addr2];

  outer_prod_gen u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x_in), .len(len),
    .k_addr(k_addr), .k_data(k_data), .result(result), .result_vld(result_vld),
    .result_idx(result_idx), .sat(sat), .done(done), .busy(busy)
  );

  outer_prod_gen #(.RND(1)) u_rnd (
    .clk(clk), .rst_n(rst_n), .start(start2), .x(x2), .len(len2),
    .k_addr(k_addr2), .k_data(k_data2), .result(result2), .result_vld(result_vld2),
    .result_idx(result_idx2), .sat(sat2), .done(done2), .busy(busy2)
  );

  typedef struct {
    logic signed [17:0] res;
    logic [9:0]         idx;
    logic               sat;
    logic               done;
    int                 cyc;
  } exp_t;

  exp_t q[$];
  exp_t q2[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input bit ok, input string name, input string info);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, info);
  endtask

  task automatic push(input bit which, input int r, input int idx, input bit s,
                      input bit d, input int c);
    exp_t e;
    e.res  = 18'(r);
    e.idx  = 10'(idx);
    e.sat  = s;
    e.done = d;
    e.cyc  = c;
    if (which) q2.push_back(e);
    else q.push_back(e);
  endtask

  // Scoreboard monitors, sampling on the falling edge
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (result_vld) begin
        if (q.size() == 0) begin
          check(1'b0, "unexpected_vld",
                $sformatf("got idx=%0d res=%0d at cyc %0d, want no output", result_idx, result, cyc));
        end else begin
          e = q.pop_front();
          check(result == e.res && result_idx == e.idx && sat == e.sat &&
                done == e.done && cyc == e.cyc, "elem",
                $sformatf("got res=%0d idx=%0d sat=%0b done=%0b cyc=%0d, want res=%0d idx=%0d sat=%0b done=%0b cyc=%0d",
                          result, result_idx, sat, done, cyc, e.res, e.idx, e.sat, e.done, e.cyc));
        end
      end else if (done) begin
        check(1'b0, "done_no_vld", $sformatf("got done=1 with vld=0 at cyc %0d, want done=0", cyc));
      end
    end
  end

  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (result_vld2) begin
        if (q2.size() == 0) begin
          check(1'b0, "rnd_unexpected_vld",
                $sformatf("got idx=%0d res=%0d at cyc %0d, want no output", result_idx2, result2, cyc));
        end else begin
          e = q2.pop_front();
          check(result2 == e.res && result_idx2 == e.idx && sat2 == e.sat &&
                done2 == e.done && cyc == e.cyc, "rnd_elem",
                $sformatf("got res=%0d idx=%0d sat=%0b done=%0b cyc=%0d, want res=%0d idx=%0d sat=%0b done=%0b cyc=%0d",
                          result2, result_idx2, sat2, done2, cyc, e.res, e.idx, e.sat, e.done, e.cyc));
        end
      end
    end
  end

  // All stimulus tasks assume they are called at posedge+#1
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_until(input int c);
    while (cyc < c) tick(1);
  endtask

  task automatic pulse(input int xv, input int lv, output int c);
    x_req = 18'(xv);
    len   = 11'(lv);
    start = 1'b1;
    c     = cyc;
    tick(1);
    start = 1'b0;
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while ((q.size() != 0 || q2.size() != 0) && n < 3000) begin
      tick(1);
      n++;
    end
    check(q.size() == 0 && q2.size() == 0, name,
          $sformatf("got %0d/%0d outstanding elements, want 0", q.size(), q2.size()));
    tick(2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no finish by time limit, want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int st;
    int st1;
    rst_n  = 1'b0;
    start  = 1'b0;
    x_req  = '0;
    len    = '0;
    start2 = 1'b0;
    x2     = 18'sd1;
    len2   = '0;
    for (int i = 0; i < 1024; i++) begin
      kmem[i]  = '0;
      kmem2[i] = '0;
    end

    // Reset held with start toggling
    for (int i = 0; i < 6; i++) begin
      @(posedge clk);
      #1;
      start = (i % 2) == 0;
      x_req = 18'sd777;
      len   = 11'd5;
      @(negedge clk);
      check(k_addr == 0 && result == 0 && !result_vld && result_idx == 0 &&
            !sat && !done && !busy, "reset_outputs",
            $sformatf("got addr=%0d res=%0d vld=%0b idx=%0d sat=%0b done=%0b busy=%0b, want all 0",
                      k_addr, result, result_vld, result_idx, sat, done, busy));
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    rst_n = 1'b1;
    tick(3);
    check(!busy && !result_vld && k_addr == 0, "idle_after_reset",
          $sformatf("got busy=%0b vld=%0b addr=%0d, want 0/0/0", busy, result_vld, k_addr));

    // Basic
    kmem[0] = 18'sd1000;
    kmem[1] = -18'sd1000;
    kmem[2] = 18'sd131071;
    kmem[3] = -18'sd131071;
    pulse(65536, 4, st);
    push(0, 500,    0, 0, 0, st + 5);
    push(0, -500,   1, 0, 0, st + 6);
    push(0, 65535,  2, 0, 0, st + 7);
    push(0, -65536, 3, 0, 1, st + 8);
    check(busy, "busy_after_start", $sformatf("got busy=%0b, want 1", busy));
    wait_until(st + 8);
    check(busy, "busy_in_done_cycle", $sformatf("got busy=%0b, want 1", busy));
    tick(1);
    check(!busy && k_addr == 3, "idle_after_done",
          $sformatf("got busy=%0b addr=%0d, want 0/3", busy, k_addr));
    drain("drain_basic");

    // Saturation of full-scale negative times full-scale negative
    kmem[0] = -18'sd131072;
    pulse(-131072, 1, st);
    push(0, 131071, 0, 1, 1, st + 5);
    drain("drain_sat");

    // Snapshot: K[i] = 16384*i, x = 1000 -> 125*i
    for (int i = 0; i < 8; i++) kmem[i] = 18'(16384 * i);
    pulse(1000, 8, st);
    for (int i = 0; i < 8; i++) push(0, 125 * i, i, 0, i == 7, st + 5 + i);
    drain("drain_snapshot");

    // Restart two cycles into a len=8 run: only the new run appears
    pulse(1000, 8, st1);
    wait_until(st1 + 2);
    pulse(2000, 3, st);
    for (int i = 0; i < 3; i++) push(0, 250 * i, i, 0, i == 2, st + 5 + i);
    drain("drain_restart");
    check(!busy, "idle_after_restart", $sformatf("got busy=%0b, want 0", busy));

    // Start in the same cycle as the last element's done
    pulse(1000, 2, st);
    push(0, 0,   0, 0, 0, st + 5);
    push(0, 125, 1, 0, 1, st + 6);
    wait_until(st + 6);
    pulse(2000, 2, st1);
    push(0, 0,   0, 0, 0, st1 + 5);
    push(0, 250, 1, 0, 1, st1 + 6);
    check(busy, "busy_across_back_to_back", $sformatf("got busy=%0b, want 1", busy));
    drain("drain_back_to_back");

    // len=0 start is ignored
    pulse(1234, 0, st);
    check(!busy && k_addr == 1, "len0_no_busy",
          $sformatf("got busy=%0b addr=%0d, want 0/1", busy, k_addr));
    tick(8);
    check(!busy && !result_vld && k_addr == 1, "len0_no_activity",
          $sformatf("got busy=%0b vld=%0b addr=%0d, want 0/0/1", busy, result_vld, k_addr));

    // Full-length run: K[i] = i-512, x = -131072 -> 512-i; a len=0 start mid-run
    for (int i = 0; i < 1024; i++) kmem[i] = 18'(i - 512);
    pulse(-131072, 1024, st);
    for (int i = 0; i < 1024; i++) push(0, 512 - i, i, 0, i == 1023, st + 5 + i);
    wait_until(st + 100);
    pulse(777, 0, st1);
    check(busy, "busy_mid_full_run", $sformatf("got busy=%0b, want 1", busy));
    drain("drain_full");
    check(!busy && k_addr == 1023, "full_run_end_addr",
          $sformatf("got busy=%0b addr=%0d, want 0/1023", busy, k_addr));

    // Round-half-up instance, x = 1
    kmem2[0] = 18'sd65536;
    kmem2[1] = 18'sd65535;
    kmem2[2] = -18'sd65537;
    kmem2[3] = -18'sd65536;
    len2   = 11'd4;
    start2 = 1'b1;
    st     = cyc;
    tick(1);
    start2 = 1'b0;
    push(1, 1,  0, 0, 0, st + 5);
    push(1, 0,  1, 0, 0, st + 6);
    push(1, -1, 2, 0, 0, st + 7);
    push(1, 0,  3, 0, 1, st + 8);
    drain("drain_rnd");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
